// File: rtl/cp0_regfile.sv
// rtl/cp0_regfile.sv - MIPS CP0 register file: BadVAddr, Count, Compare, Status, Cause, EPC
//
// Purpose: holds the coprocessor-0 state, resolves the MEM-stage exception
// with fixed priority, produces the flush/redirect request and the timer
// interrupt, and services mfc0 reads / mtc0 writes.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   mem_valid           MEM-stage instruction valid (qualifies mem_*)
//   mem_pc              PC of the MEM-stage instruction
//   mem_in_delayslot    MEM-stage instruction is in a branch delay slot
//   mem_excepttype      {eret, AdES, AdEL-data, Bp, Sys, Ov, RI, AdEL-fetch}
//   mem_badvaddr        faulting data address for AdEL-data / AdES
//   mtc0_we/addr/wdata  CP0 register write, commits at the clock edge
//   mfc0_re/addr        CP0 register read request
//   hw_int              level-sensitive external interrupt lines
//   mfc0_rdata          combinational read data (pre-edge register value)
//   cp0_to_ctrl_bus     [32] flush request, [31:0] redirect PC
//   stallreq_for_cp0    read-after-write hazard stall
//   timer_int           Cause.TI
module cp0_regfile (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_valid,
   input  logic [31:0] mem_pc,
   input  logic        mem_in_delayslot,
   input  logic [7:0]  mem_excepttype,
   input  logic [31:0] mem_badvaddr,
   input  logic        mtc0_we,
   input  logic [4:0]  mtc0_addr,
   input  logic [31:0] mtc0_wdata,
   input  logic        mfc0_re,
   input  logic [4:0]  mfc0_addr,
   input  logic [5:0]  hw_int,
   output logic [31:0] mfc0_rdata,
   output logic [32:0] cp0_to_ctrl_bus,
   output logic        stallreq_for_cp0,
   output logic        timer_int
);

   localparam logic [4:0]  ADDR_BADVADDR = 5'd8;
   localparam logic [4:0]  ADDR_COUNT    = 5'd9;
   localparam logic [4:0]  ADDR_COMPARE  = 5'd11;
   localparam logic [4:0]  ADDR_STATUS   = 5'd12;
   localparam logic [4:0]  ADDR_CAUSE    = 5'd13;
   localparam logic [4:0]  ADDR_EPC      = 5'd14;

   localparam logic [4:0]  EXC_INT  = 5'h00;
   localparam logic [4:0]  EXC_ADEL = 5'h04;
   localparam logic [4:0]  EXC_ADES = 5'h05;
   localparam logic [4:0]  EXC_SYS  = 5'h08;
   localparam logic [4:0]  EXC_BP   = 5'h09;
   localparam logic [4:0]  EXC_RI   = 5'h0a;
   localparam logic [4:0]  EXC_OV   = 5'h0c;

   localparam logic [31:0] EXC_VECTOR = 32'hbfc0_0380;

   logic [31:0] badvaddr_q, badvaddr_d;
   logic [31:0] count_q, count_d;
   logic        toggle_q, toggle_d;
   logic [31:0] compare_q, compare_d;
   logic [7:0]  status_im_q, status_im_d;
   logic        status_exl_q, status_exl_d;
   logic        status_ie_q, status_ie_d;
   logic        cause_bd_q, cause_bd_d;
   logic        cause_ti_q, cause_ti_d;
   logic [5:0]  cause_ip_hw_q, cause_ip_hw_d;
   logic [1:0]  cause_ip_sw_q, cause_ip_sw_d;
   logic [4:0]  cause_exccode_q, cause_exccode_d;
   logic [31:0] epc_q, epc_d;

   logic [31:0] status_rd;
   logic [31:0] cause_rd;
   logic        int_pending;
   logic        exc_any;
   logic        is_eret;
   logic        take_exc;
   logic        take_eret;
   logic        mtc0_commit;
   logic [4:0]  exc_code;
   logic        bva_from_pc;
   logic        bva_from_bad;

   assign status_rd = {9'd0, 1'b1, 6'd0, status_im_q, 6'd0, status_exl_q, status_ie_q};
   assign cause_rd  = {cause_bd_q, cause_ti_q, 14'd0, cause_ip_hw_q, cause_ip_sw_q,
                       1'b0, cause_exccode_q, 2'b00};

   assign int_pending = status_ie_q & ~status_exl_q &
                        (|({cause_ip_hw_q, cause_ip_sw_q} & status_im_q));
   assign exc_any     = mem_valid & (int_pending | (|mem_excepttype));

   // Priority resolution. eret is carried as a pseudo-exception so it
   // shares the flush path but only redirects to EPC and clears EXL.
   always_comb begin
      is_eret      = 1'b0;
      exc_code     = EXC_INT;
      bva_from_pc  = 1'b0;
      bva_from_bad = 1'b0;
      if (int_pending) begin
         exc_code = EXC_INT;
      end else if (mem_excepttype[0]) begin
         exc_code    = EXC_ADEL;
         bva_from_pc = 1'b1;
      end else if (mem_excepttype[1]) begin
         exc_code = EXC_RI;
      end else if (mem_excepttype[2]) begin
         exc_code = EXC_OV;
      end else if (mem_excepttype[3]) begin
         exc_code = EXC_SYS;
      end else if (mem_excepttype[4]) begin
         exc_code = EXC_BP;
      end else if (mem_excepttype[7]) begin
         is_eret = 1'b1;
      end else if (mem_excepttype[5]) begin
         exc_code     = EXC_ADEL;
         bva_from_bad = 1'b1;
      end else if (mem_excepttype[6]) begin
         exc_code     = EXC_ADES;
         bva_from_bad = 1'b1;
      end
   end

   assign take_exc    = exc_any & ~is_eret;
   assign take_eret   = exc_any & is_eret;
   // The faulting instruction's own mtc0 never retires.
   assign mtc0_commit = mtc0_we & ~exc_any;

   always_comb begin
      badvaddr_d      = badvaddr_q;
      count_d         = count_q;
      toggle_d        = ~toggle_q;
      compare_d       = compare_q;
      status_im_d     = status_im_q;
      status_exl_d    = status_exl_q;
      status_ie_d     = status_ie_q;
      cause_bd_d      = cause_bd_q;
      cause_ti_d      = cause_ti_q;
      cause_ip_hw_d   = {cause_ti_q | hw_int[5], hw_int[4:0]};
      cause_ip_sw_d   = cause_ip_sw_q;
      cause_exccode_d = cause_exccode_q;
      epc_d           = epc_q;

      if (toggle_q) begin
         count_d = count_q + 32'd1;
      end

      // Software writes first; hardware updates below override them.
      if (mtc0_commit) begin
         case (mtc0_addr)
            ADDR_BADVADDR: badvaddr_d = mtc0_wdata;
            ADDR_COUNT: begin
               count_d  = mtc0_wdata;
               toggle_d = 1'b0;
            end
            ADDR_COMPARE: begin
               compare_d  = mtc0_wdata;
               cause_ti_d = 1'b0;
            end
            ADDR_STATUS: begin
               status_im_d  = mtc0_wdata[15:8];
               status_exl_d = mtc0_wdata[1];
               status_ie_d  = mtc0_wdata[0];
            end
            ADDR_CAUSE:    cause_ip_sw_d = mtc0_wdata[9:8];
            ADDR_EPC:      epc_d = mtc0_wdata;
            default: ;
         endcase
      end

      // Compare == 0 is treated as "timer disabled".
      if ((count_q == compare_q) && (compare_q != 32'd0)) begin
         cause_ti_d = 1'b1;
      end

      if (take_eret) begin
         status_exl_d = 1'b0;
      end

      if (take_exc) begin
         // A nested exception keeps the original EPC/BD.
         if (!status_exl_q) begin
            epc_d      = mem_in_delayslot ? (mem_pc - 32'd4) : mem_pc;
            cause_bd_d = mem_in_delayslot;
         end
         status_exl_d    = 1'b1;
         cause_exccode_d = exc_code;
         if (bva_from_pc) begin
            badvaddr_d = mem_pc;
         end else if (bva_from_bad) begin
            badvaddr_d = mem_badvaddr;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         badvaddr_q      <= 32'd0;
         count_q         <= 32'd0;
         toggle_q        <= 1'b0;
         compare_q       <= 32'd0;
         status_im_q     <= 8'd0;
         status_exl_q    <= 1'b0;
         status_ie_q     <= 1'b0;
         cause_bd_q      <= 1'b0;
         cause_ti_q      <= 1'b0;
         cause_ip_hw_q   <= 6'd0;
         cause_ip_sw_q   <= 2'd0;
         cause_exccode_q <= 5'd0;
         epc_q           <= 32'd0;
      end else begin
         badvaddr_q      <= badvaddr_d;
         count_q         <= count_d;
         toggle_q        <= toggle_d;
         compare_q       <= compare_d;
         status_im_q     <= status_im_d;
         status_exl_q    <= status_exl_d;
         status_ie_q     <= status_ie_d;
         cause_bd_q      <= cause_bd_d;
         cause_ti_q      <= cause_ti_d;
         cause_ip_hw_q   <= cause_ip_hw_d;
         cause_ip_sw_q   <= cause_ip_sw_d;
         cause_exccode_q <= cause_exccode_d;
         epc_q           <= epc_d;
      end
   end

   always_comb begin
      cp0_to_ctrl_bus = 33'd0;
      if (!rst) begin
         if (take_eret) begin
            cp0_to_ctrl_bus = {1'b1, epc_q};
         end else if (take_exc) begin
            cp0_to_ctrl_bus = {1'b1, EXC_VECTOR};
         end
      end
   end

   always_comb begin
      mfc0_rdata = 32'd0;
      case (mfc0_addr)
         ADDR_BADVADDR: mfc0_rdata = badvaddr_q;
         ADDR_COUNT:    mfc0_rdata = count_q;
         ADDR_COMPARE:  mfc0_rdata = compare_q;
         ADDR_STATUS:   mfc0_rdata = status_rd;
         ADDR_CAUSE:    mfc0_rdata = cause_rd;
         ADDR_EPC:      mfc0_rdata = epc_q;
         default:       mfc0_rdata = 32'd0;
      endcase
   end

   assign stallreq_for_cp0 = ~rst & mfc0_re & mtc0_we & mem_valid & (mfc0_addr == mtc0_addr);
   assign timer_int        = cause_ti_q;

endmodule

// File: tb/tb_cp0_regfile.sv
// tb/tb_cp0_regfile.sv - self-checking bench for cp0_regfile
module tb_cp0_regfile;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_valid;
   logic [31:0] mem_pc;
   logic        mem_in_delayslot;
   logic [7:0]  mem_excepttype;
   logic [31:0] mem_badvaddr;
   logic        mtc0_we;
   logic [4:0]  mtc0_addr;
   logic [31:0] mtc0_wdata;
   logic        mfc0_re;
   logic [4:0]  mfc0_addr;
   logic [5:0]  hw_int;
   logic [31:0] mfc0_rdata;
   logic [32:0] cp0_to_ctrl_bus;
   logic        stallreq_for_cp0;
   logic        timer_int;

   always #5 clk = ~clk;

   cp0_regfile dut (
      .clk              (clk),
      .rst              (rst),
      .mem_valid        (mem_valid),
      .mem_pc           (mem_pc),
      .mem_in_delayslot (mem_in_delayslot),
      .mem_excepttype   (mem_excepttype),
      .mem_badvaddr     (mem_badvaddr),
      .mtc0_we          (mtc0_we),
      .mtc0_addr        (mtc0_addr),
      .mtc0_wdata       (mtc0_wdata),
      .mfc0_re          (mfc0_re),
      .mfc0_addr        (mfc0_addr),
      .hw_int           (hw_int),
      .mfc0_rdata       (mfc0_rdata),
      .cp0_to_ctrl_bus  (cp0_to_ctrl_bus),
      .stallreq_for_cp0 (stallreq_for_cp0),
      .timer_int        (timer_int)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: architectural register values; Count is derived from
   // the number of edges since its last load.
   logic [31:0] m_status, m_cause, m_epc, m_badv, m_compare, m_count_base;
   int unsigned m_cyc;

   function automatic logic [31:0] m_count();
      return m_count_base + (m_cyc >> 1);
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] a);
      case (a)
         5'd8:    return m_badv;
         5'd9:    return m_count();
         5'd11:   return m_compare;
         5'd12:   return m_status;
         5'd13:   return m_cause;
         5'd14:   return m_epc;
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_reset();
      m_status = 32'h0040_0000;
      m_cause = 0; m_epc = 0; m_badv = 0; m_compare = 0; m_count_base = 0; m_cyc = 0;
   endtask

   task automatic decide(output bit exc, output bit eret, output logic [4:0] code, output int bsrc);
      int          prio[8]  = '{0, 1, 2, 3, 4, 7, 5, 6};
      logic [4:0]  codes[8] = '{5'h04, 5'h0A, 5'h0C, 5'h08, 5'h09, 5'h04, 5'h05, 5'h00};
      logic [7:0]  ip;
      bit          pend, found;
      ip   = m_cause[15:8];
      pend = m_status[0] && !m_status[1] && ((ip & m_status[15:8]) != 0);
      exc  = mem_valid && (pend || mem_excepttype != 0);
      eret = 0; code = 5'h00; bsrc = 0; found = 0;
      if (exc && !pend) begin
         for (int k = 0; k < 8; k++) begin
            if (!found && mem_excepttype[prio[k]]) begin
               found = 1;
               if (prio[k] == 7) eret = 1;
               else begin
                  code = codes[prio[k]];
                  if (prio[k] == 0) bsrc = 1;
                  else if (prio[k] == 5 || prio[k] == 6) bsrc = 2;
               end
            end
         end
      end
   endtask

   task automatic model_update(input bit exc, input bit eret, input logic [4:0] code, input int bsrc);
      logic [31:0] cnt;
      logic [31:0] cmp_old;
      logic        ti_old, exl_old;
      bit          wen;
      cnt = m_count(); cmp_old = m_compare; ti_old = m_cause[30]; exl_old = m_status[1];
      wen = mtc0_we && !exc;
      if (wen && mtc0_addr == 5'd9) begin
         m_count_base = mtc0_wdata; m_cyc = 0;
      end else m_cyc++;
      if (wen) begin
         case (mtc0_addr)
            5'd8:  m_badv = mtc0_wdata;
            5'd11: begin m_compare = mtc0_wdata; m_cause[30] = 1'b0; end
            5'd12: m_status = (mtc0_wdata & 32'h0000_FF03) | 32'h0040_0000;
            5'd13: m_cause[9:8] = mtc0_wdata[9:8];
            5'd14: m_epc = mtc0_wdata;
            default: ;
         endcase
      end
      if (cnt == cmp_old && cmp_old != 0) m_cause[30] = 1'b1;
      m_cause[15:10] = {ti_old | hw_int[5], hw_int[4:0]};
      if (eret) m_status[1] = 1'b0;
      else if (exc) begin
         if (!exl_old) begin
            m_epc = mem_in_delayslot ? mem_pc - 32'd4 : mem_pc;
            m_cause[31] = mem_in_delayslot;
         end
         m_status[1] = 1'b1;
         m_cause[6:2] = code;
         if (bsrc == 1) m_badv = mem_pc;
         else if (bsrc == 2) m_badv = mem_badvaddr;
      end
   endtask

   logic [31:0] s_rdata;
   logic [32:0] s_bus;
   logic        s_stall, s_ti;

   // One clock: sample and check on the falling edge, advance the model, return #1 after the rising edge.
   task automatic step();
      bit exc, eret; logic [4:0] code; int bsrc;
      logic [32:0] e_bus;
      @(negedge clk);
      if (rst) model_reset();
      decide(exc, eret, code, bsrc);
      e_bus = rst ? 33'd0 : eret ? {1'b1, m_epc} : exc ? {1'b1, 32'hBFC0_0380} : 33'd0;
      s_rdata = mfc0_rdata; s_bus = cp0_to_ctrl_bus; s_stall = stallreq_for_cp0; s_ti = timer_int;
      chk($sformatf("model_rdata[a%0d]", mfc0_addr), s_rdata, m_read(mfc0_addr));
      chk("model_bus", s_bus, e_bus);
      chk("model_stall", s_stall, !rst && mfc0_re && mtc0_we && mem_valid && mfc0_addr == mtc0_addr);
      chk("model_timer_int", s_ti, m_cause[30]);
      if (!rst) model_update(exc, eret, code, bsrc);
      @(posedge clk); #1;
   endtask

   task automatic idle();
      mem_valid = 0; mem_pc = 0; mem_in_delayslot = 0; mem_excepttype = 0; mem_badvaddr = 0;
      mtc0_we = 0; mtc0_addr = 0; mtc0_wdata = 0; mfc0_re = 0; mfc0_addr = 0; hw_int = 0;
   endtask

   task automatic do_reset();
      idle(); rst = 1; step(); step(); rst = 0;
   endtask

   task automatic rd(input logic [4:0] a, output logic [31:0] v);
      idle(); mfc0_re = 1; mfc0_addr = a; step(); v = s_rdata;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      idle(); mem_valid = 1; mtc0_we = 1; mtc0_addr = a; mtc0_wdata = d; step();
   endtask

   task automatic exc_step(input logic [7:0] et, input logic [31:0] pc, input logic ds, input logic [31:0] bva);
      idle(); mem_valid = 1; mem_excepttype = et; mem_pc = pc; mem_in_delayslot = ds; mem_badvaddr = bva; step();
   endtask

   typedef struct {
      logic        valid;
      logic [7:0]  et;
      logic [31:0] pc;
      logic        ds;
      logic [31:0] bva_in;
      logic [32:0] bus;
      logic [31:0] cause;
      logic [31:0] epc;
      logic [31:0] bva;
   } vec_t;

   vec_t vecs[10];

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] v;
      int n;
      bit seen;
      logic [4:0] addrs[8];

      vecs[0] = '{1, 8'h08, 32'hBFC0_0100, 0, 32'h0,  33'h1_BFC0_0380, 32'h0000_0020, 32'hBFC0_0100, 32'h0};
      vecs[1] = '{1, 8'h04, 32'h8000_1004, 1, 32'h0,  33'h1_BFC0_0380, 32'h8000_0030, 32'h8000_1000, 32'h0};
      vecs[2] = '{1, 8'h22, 32'h8000_0010, 0, 32'h13, 33'h1_BFC0_0380, 32'h0000_0028, 32'h8000_0010, 32'h0};
      vecs[3] = '{1, 8'h01, 32'h8000_0123, 0, 32'h0,  33'h1_BFC0_0380, 32'h0000_0010, 32'h8000_0123, 32'h8000_0123};
      vecs[4] = '{1, 8'h40, 32'h8000_0200, 0, 32'h44, 33'h1_BFC0_0380, 32'h0000_0014, 32'h8000_0200, 32'h44};
      vecs[5] = '{1, 8'h50, 32'h8000_0300, 0, 32'h55, 33'h1_BFC0_0380, 32'h0000_0024, 32'h8000_0300, 32'h0};
      vecs[6] = '{1, 8'h80, 32'h8000_0400, 0, 32'h0,  33'h1_0000_0000, 32'h0,         32'h0,         32'h0};
      vecs[7] = '{1, 8'hA0, 32'h8000_0400, 0, 32'h66, 33'h1_0000_0000, 32'h0,         32'h0,         32'h0};
      vecs[8] = '{1, 8'h00, 32'h8000_0500, 0, 32'h0,  33'h0,           32'h0,         32'h0,         32'h0};
      vecs[9] = '{0, 8'h08, 32'h8000_0600, 0, 32'h0,  33'h0,           32'h0,         32'h0,         32'h0};

      idle();
      model_reset();

      // Reset holds outputs quiet even with a hazard and exception presented.
      rst = 1;
      mem_valid = 1; mem_excepttype = 8'h08; mtc0_we = 1; mtc0_addr = 12; mtc0_wdata = 32'hFFFF_FFFF;
      mfc0_re = 1; mfc0_addr = 12;
      step();
      chk("reset_bus", s_bus, 33'd0);
      chk("reset_stall", s_stall, 1'b0);
      chk("reset_timer_int", s_ti, 1'b0);
      chk("reset_status", s_rdata, 32'h0040_0000);
      do_reset();

      // Table of single exceptions from reset state.
      foreach (vecs[i]) begin
         do_reset();
         idle();
         mem_valid = vecs[i].valid; mem_excepttype = vecs[i].et; mem_pc = vecs[i].pc;
         mem_in_delayslot = vecs[i].ds; mem_badvaddr = vecs[i].bva_in;
         step();
         chk($sformatf("vec%0d_bus", i), s_bus, vecs[i].bus);
         rd(13, v); chk($sformatf("vec%0d_cause", i), v, vecs[i].cause);
         rd(14, v); chk($sformatf("vec%0d_epc", i), v, vecs[i].epc);
         rd(8, v);  chk($sformatf("vec%0d_badvaddr", i), v, vecs[i].bva);
      end

      // Delay-slot overflow then eret.
      do_reset();
      exc_step(8'h04, 32'h8000_1004, 1, 0);
      rd(14, v); chk("ds_epc", v, 32'h8000_1000);
      rd(12, v); chk("ds_status_exl", v, 32'h0040_0002);
      exc_step(8'h80, 32'h8000_2000, 0, 0);
      chk("eret_bus", s_bus, 33'h1_8000_1000);
      rd(12, v); chk("eret_status", v, 32'h0040_0000);

      // Nested exception keeps EPC but still flushes.
      do_reset();
      exc_step(8'h08, 32'h8000_0100, 0, 0);
      exc_step(8'h08, 32'h8000_0200, 1, 0);
      chk("nested_bus", s_bus, 33'h1_BFC0_0380);
      rd(14, v); chk("nested_epc", v, 32'h8000_0100);
      rd(13, v); chk("nested_cause", v, 32'h0000_0020);

      // mtc0/mfc0 hazard on Status.
      do_reset();
      idle(); mem_valid = 1; mtc0_we = 1; mtc0_addr = 12; mtc0_wdata = 32'h0000_FF01;
      mfc0_re = 1; mfc0_addr = 12;
      step();
      chk("hazard_stall", s_stall, 1'b1);
      chk("hazard_old_rdata", s_rdata, 32'h0040_0000);
      rd(12, v); chk("hazard_new_rdata", v, 32'h0040_FF01);

      // Timer interrupt.
      do_reset();
      wr(11, 32'h10);
      seen = 0; n = 0;
      while (!seen && n < 80) begin
         idle(); step(); n++;
         seen = s_ti;
      end
      chk("timer_seen", seen, 1'b1);
      chk("timer_latency_ok", (n >= 30 && n <= 36), 1'b1);
      wr(12, 32'h0040_8001);
      idle(); mem_valid = 1; step();
      chk("timer_int_bus", s_bus, 33'h1_BFC0_0380);
      rd(13, v); chk("timer_cause", v & 32'hC000_807C, 32'h4000_8000);
      wr(11, 32'h0);
      idle(); step();
      chk("timer_cleared", s_ti, 1'b0);

      // Count write wins over the increment, then wraps.
      do_reset();
      idle(); step();
      wr(9, 32'hFFFF_FFFF);
      rd(9, v); chk("count_load", v, 32'hFFFF_FFFF);
      rd(9, v); chk("count_hold", v, 32'hFFFF_FFFF);
      rd(9, v); chk("count_wrap", v, 32'h0);

      // Reset asserted mid-exception.
      do_reset();
      idle(); mem_valid = 1; mem_excepttype = 8'h08; mem_pc = 32'h8000_0500;
      #2 rst = 1;
      step();
      chk("midrst_bus", s_bus, 33'd0);
      rst = 0;
      rd(14, v); chk("midrst_epc0", v, 32'h0);
      rd(14, v); chk("midrst_epc1", v, 32'h0);
      rd(12, v); chk("midrst_status", v, 32'h0040_0000);

      // Randomized run against the model.
      do_reset();
      addrs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd3, 5'd11};
      for (int i = 0; i < 400; i++) begin
         int r;
         mem_valid = ($urandom_range(0, 3) != 0);
         mem_pc = $urandom & 32'hFFFF_FFFC;
         mem_in_delayslot = 1'($urandom_range(0, 1));
         r = $urandom_range(0, 9);
         mem_excepttype = (r < 6) ? 8'h00 : (r < 9) ? 8'(1 << $urandom_range(0, 7)) : 8'($urandom);
         mem_badvaddr = $urandom;
         mtc0_we = ($urandom_range(0, 2) == 0);
         mtc0_addr = addrs[$urandom_range(0, 7)];
         if (mtc0_addr == 5'd6 - 5'd3) mtc0_addr = 5'($urandom);
         mtc0_wdata = (mtc0_addr == 5'd11) ? m_count() + $urandom_range(0, 6) : $urandom;
         mfc0_re = 1'($urandom_range(0, 1));
         mfc0_addr = ($urandom_range(0, 1) == 0) ? mtc0_addr : addrs[$urandom_range(0, 7)];
         hw_int = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
